// File: rtl/reg_writeback_queue.sv
// Write-back queue in front of the register file: arbitrates ALU/LSU results,
// buffers them in order, drains one per cycle and serves read-port bypass lookups.
module reg_writeback_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned DATA_W       = 32,
  parameter bit          ZERO_DISCARD = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_dest,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_W-1:0]        lsu_dest,
  input  logic [DATA_W-1:0]        lsu_data,
  input  logic                     wb_hold,
  output logic                     rf_write_enable,
  output logic [ADDR_W-1:0]        rf_dest,
  output logic [DATA_W-1:0]        rf_data,
  input  logic [ADDR_W-1:0]        src_one,
  input  logic [ADDR_W-1:0]        src_two,
  output logic                     byp_one_hit,
  output logic [DATA_W-1:0]        byp_one_data,
  output logic                     byp_two_hit,
  output logic [DATA_W-1:0]        byp_two_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             favour_lsu;

  logic   alu_fire;
  logic   lsu_fire;
  logic   push;
  logic   pop;
  entry_t in_entry;

  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));

  // Ready looks only at the other port's valid; a same-cycle pop does not free space.
  assign alu_ready = !reset && !full && (!lsu_valid || !favour_lsu);
  assign lsu_ready = !reset && !full && (!alu_valid || favour_lsu);
  assign alu_fire  = alu_valid && alu_ready;
  assign lsu_fire  = lsu_valid && lsu_ready;

  assign in_entry = lsu_fire ? entry_t'{dest: lsu_dest, data: lsu_data}
                             : entry_t'{dest: alu_dest, data: alu_data};
  assign push     = (alu_fire || lsu_fire) &&
                    !(ZERO_DISCARD && (in_entry.dest == '0));

  assign rf_write_enable = !reset && !empty && !wb_hold;
  assign pop             = rf_write_enable;
  assign rf_dest         = empty ? '0 : mem[rd_ptr].dest;
  assign rf_data         = empty ? '0 : mem[rd_ptr].data;

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    byp_one_hit  = 1'b0;
    byp_one_data = '0;
    byp_two_hit  = 1'b0;
    byp_two_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (CNT_W'(i) < cnt) begin
        if (mem[rd_ptr + PTR_W'(i)].dest == src_one) begin
          byp_one_hit  = 1'b1;
          byp_one_data = mem[rd_ptr + PTR_W'(i)].data;
        end
        if (mem[rd_ptr + PTR_W'(i)].dest == src_two) begin
          byp_two_hit  = 1'b1;
          byp_two_data = mem[rd_ptr + PTR_W'(i)].data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      favour_lsu <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      // Round-robin moves on any completed handshake, discarded or not.
      if (alu_fire) begin
        favour_lsu <= 1'b1;
      end else if (lsu_fire) begin
        favour_lsu <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: two instances (ZERO_DISCARD 0/1) checked every
// cycle against a list-based model, plus directed literal expectations.
module tb_reg_writeback_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, lsu_valid, wb_hold;
  logic [2:0]  alu_dest, lsu_dest, src_one, src_two;
  logic [31:0] alu_data, lsu_data;

  logic        alu_ready0, lsu_ready0, we0, hit1_0, hit2_0, full0, empty0;
  logic [2:0]  rf_dest0, count0;
  logic [31:0] rf_data0, bd1_0, bd2_0;
  logic        alu_ready1, lsu_ready1, we1, hit1_1, hit2_1, full1, empty1;
  logic [2:0]  rf_dest1, count1;
  logic [31:0] rf_data1, bd1_1, bd2_1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_writeback_queue #(.DEPTH(4), .ADDR_W(3), .DATA_W(32), .ZERO_DISCARD(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready0), .alu_dest(alu_dest), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready0), .lsu_dest(lsu_dest), .lsu_data(lsu_data),
    .wb_hold(wb_hold), .rf_write_enable(we0), .rf_dest(rf_dest0), .rf_data(rf_data0),
    .src_one(src_one), .src_two(src_two),
    .byp_one_hit(hit1_0), .byp_one_data(bd1_0), .byp_two_hit(hit2_0), .byp_two_data(bd2_0),
    .count(count0), .full(full0), .empty(empty0)
  );

  reg_writeback_queue #(.DEPTH(4), .ADDR_W(3), .DATA_W(32), .ZERO_DISCARD(1'b1)) dut1 (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready1), .alu_dest(alu_dest), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready1), .lsu_dest(lsu_dest), .lsu_data(lsu_data),
    .wb_hold(wb_hold), .rf_write_enable(we1), .rf_dest(rf_dest1), .rf_data(rf_data1),
    .src_one(src_one), .src_two(src_two),
    .byp_one_hit(hit1_1), .byp_one_data(bd1_1), .byp_two_hit(hit2_1), .byp_two_data(bd2_1),
    .count(count1), .full(full1), .empty(empty1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Model: per instance an ordered list (index 0 = oldest) and who was granted last.
  typedef struct packed { logic [2:0] dest; logic [31:0] data; } ent_t;
  ent_t mq [2][8];
  int   mn [2];
  bit   last_alu [2];
  bit   armed = 1'b0;

  logic        ar, lr, we, fl, em, h1, h2;
  logic [2:0]  cnt, rd;
  logic [31:0] rdat, d1, d2;
  bit          g_alu, g_lsu, e_full, e_we, e_h1, e_h2;
  logic [31:0] e_d1, e_d2;
  ent_t        e_new;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        ar = alu_ready0; lr = lsu_ready0; we = we0; fl = full0; em = empty0; cnt = count0;
        rd = rf_dest0; rdat = rf_data0; h1 = hit1_0; h2 = hit2_0; d1 = bd1_0; d2 = bd2_0;
      end else begin
        ar = alu_ready1; lr = lsu_ready1; we = we1; fl = full1; em = empty1; cnt = count1;
        rd = rf_dest1; rdat = rf_data1; h1 = hit1_1; h2 = hit2_1; d1 = bd1_1; d2 = bd2_1;
      end
      e_full = (mn[k] == 4);
      g_alu = 1'b0;
      g_lsu = 1'b0;
      if (!reset && !e_full) begin
        if (alu_valid && lsu_valid) begin
          g_alu = !last_alu[k];
          g_lsu = last_alu[k];
        end else begin
          g_alu = alu_valid;
          g_lsu = lsu_valid;
        end
      end
      e_we = !reset && (mn[k] > 0) && !wb_hold;
      e_h1 = 1'b0; e_d1 = '0; e_h2 = 1'b0; e_d2 = '0;
      for (int i = mn[k] - 1; i >= 0; i--) begin
        if (!e_h1 && mq[k][i].dest == src_one) begin e_h1 = 1'b1; e_d1 = mq[k][i].data; end
        if (!e_h2 && mq[k][i].dest == src_two) begin e_h2 = 1'b1; e_d2 = mq[k][i].data; end
      end

      if (reset) begin
        chk($sformatf("d%0d alu_ready in reset", k), 32'(ar), 32'd0);
        chk($sformatf("d%0d lsu_ready in reset", k), 32'(lr), 32'd0);
        chk($sformatf("d%0d rf_write_enable in reset", k), 32'(we), 32'd0);
      end else if (armed) begin
        if (alu_valid || e_full) chk($sformatf("d%0d alu_ready", k), 32'(ar), 32'(g_alu));
        if (lsu_valid || e_full) chk($sformatf("d%0d lsu_ready", k), 32'(lr), 32'(g_lsu));
        chk($sformatf("d%0d count", k), 32'(cnt), 32'(mn[k]));
        chk($sformatf("d%0d full", k), 32'(fl), 32'(e_full));
        chk($sformatf("d%0d empty", k), 32'(em), 32'(mn[k] == 0));
        chk($sformatf("d%0d rf_write_enable", k), 32'(we), 32'(e_we));
        chk($sformatf("d%0d rf_dest", k), 32'(rd), (mn[k] > 0) ? 32'(mq[k][0].dest) : 32'd0);
        chk($sformatf("d%0d rf_data", k), rdat, (mn[k] > 0) ? mq[k][0].data : 32'd0);
        chk($sformatf("d%0d byp_one_hit", k), 32'(h1), 32'(e_h1));
        chk($sformatf("d%0d byp_one_data", k), d1, e_d1);
        chk($sformatf("d%0d byp_two_hit", k), 32'(h2), 32'(e_h2));
        chk($sformatf("d%0d byp_two_data", k), d2, e_d2);
      end

      // Advance the model to what the coming rising edge must do.
      if (reset) begin
        mn[k] = 0;
        last_alu[k] = 1'b0;
      end else if (armed) begin
        if (e_we) begin
          for (int i = 0; i < mn[k] - 1; i++) mq[k][i] = mq[k][i+1];
          mn[k]--;
        end
        if (g_alu || g_lsu) begin
          last_alu[k] = g_alu;
          e_new = g_alu ? ent_t'{dest: alu_dest, data: alu_data}
                        : ent_t'{dest: lsu_dest, data: lsu_data};
          if (!(k == 1 && e_new.dest == 3'd0)) begin
            mq[k][mn[k]] = e_new;
            mn[k]++;
          end
        end
      end
    end
    if (reset) armed = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int budget);
    bit found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clk);
      if (empty0 && empty1) found = 1'b1;
      step();
    end
    chk("wait_empty within budget", 32'(found), 32'd1);
  endtask

  bit          af, lf;
  logic [31:0] prev;
  int          ai, li;

  initial begin
    reset = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0; wb_hold = 1'b0;
    alu_dest = '0; lsu_dest = '0; alu_data = '0; lsu_data = '0; src_one = '0; src_two = '0;
    step(); step();
    reset = 1'b0;

    // Single result: one-cycle latency to the RF port.
    alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("lit first alu_ready", 32'(alu_ready0), 32'd1);
    chk("lit reset count", 32'(count0), 32'd0);
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("lit first we", 32'(we0), 32'd1);
    chk("lit first rf_dest", 32'(rf_dest0), 32'd3);
    chk("lit first rf_data", rf_data0, 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("lit empty after drain", 32'(empty0), 32'd1);
    step();

    // Fill under hold, fifth write blocked, then in-order drain.
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_dest = 3'(i + 1); alu_data = 32'(100 + i);
      step();
    end
    alu_dest = 3'd5; alu_data = 32'd104;
    @(negedge clk);
    chk("lit full", 32'(full0), 32'd1);
    chk("lit count 4", 32'(count0), 32'd4);
    chk("lit fifth alu_ready", 32'(alu_ready0), 32'd0);
    step();
    wb_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("lit drain order %0d", i), 32'(rf_dest0), 32'(i + 1));
      af = alu_valid && alu_ready0;
      step();
      if (af) alu_valid = 1'b0;
    end
    wait_empty(10);

    // Both producers valid: grants alternate starting with ALU.
    reset = 1'b1; step(); reset = 1'b0;
    alu_valid = 1'b1; lsu_valid = 1'b1; alu_dest = 3'd1; lsu_dest = 3'd2;
    ai = 0; li = 0; alu_data = 32'hA000_0000; lsu_data = 32'hB000_0000; prev = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("lit grant alu %0d", c), 32'(alu_ready0), 32'((c % 2) == 0));
      chk($sformatf("lit grant lsu %0d", c), 32'(lsu_ready0), 32'((c % 2) == 1));
      if (c > 0) chk($sformatf("lit rf_data order %0d", c), rf_data0, prev);
      af = alu_ready0; lf = lsu_ready0;
      prev = af ? alu_data : lsu_data;
      step();
      if (af) begin ai++; alu_data = 32'hA000_0000 + 32'(ai); end
      if (lf) begin li++; lsu_data = 32'hB000_0000 + 32'(li); end
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge clk);
    chk("lit last rf_data", rf_data0, 32'hB000_0001);
    step();
    wait_empty(10);

    // Bypass: youngest of two writes to r5 wins, r6 misses.
    wb_hold = 1'b1;
    alu_valid = 1'b1; alu_dest = 3'd5; alu_data = 32'h11; step();
    alu_data = 32'h22; step();
    alu_valid = 1'b0; src_one = 3'd5; src_two = 3'd6;
    @(negedge clk);
    chk("lit byp_one_hit", 32'(hit1_0), 32'd1);
    chk("lit byp_one_data", bd1_0, 32'h22);
    chk("lit byp_two_hit", 32'(hit2_0), 32'd0);
    chk("lit byp_two_data", bd2_0, 32'd0);
    step();
    wb_hold = 1'b0;
    wait_empty(10);

    // Writes to r0: dropped by the ZERO_DISCARD instance, kept by the other.
    alu_valid = 1'b1; alu_dest = 3'd0; alu_data = 32'h55;
    @(negedge clk);
    chk("lit zd0 ready", 32'(alu_ready0), 32'd1);
    chk("lit zd1 ready", 32'(alu_ready1), 32'd1);
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("lit zd1 count", 32'(count1), 32'd0);
    chk("lit zd1 we", 32'(we1), 32'd0);
    chk("lit zd0 count", 32'(count0), 32'd1);
    chk("lit zd0 we", 32'(we0), 32'd1);
    chk("lit zd0 rf_data", rf_data0, 32'h55);
    step();
    wait_empty(10);

    // Reset with three held entries discards them.
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_dest = 3'(i + 1); alu_data = 32'h300 + 32'(i);
      step();
    end
    alu_valid = 1'b0;
    @(negedge clk);
    chk("lit count 3", 32'(count0), 32'd3);
    step();
    reset = 1'b1; wb_hold = 1'b0; alu_valid = 1'b1; lsu_valid = 1'b1;
    @(negedge clk);
    chk("lit alu_ready in reset", 32'(alu_ready0), 32'd0);
    chk("lit lsu_ready in reset", 32'(lsu_ready0), 32'd0);
    chk("lit we in reset", 32'(we0), 32'd0);
    step();
    reset = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("lit post-reset we %0d", i), 32'(we0), 32'd0);
      chk($sformatf("lit post-reset count %0d", i), 32'(count0), 32'd0);
      chk($sformatf("lit post-reset empty %0d", i), 32'(empty0), 32'd1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Write-side front end for the 8-entry register file: gathers results from two producers (ALU, LSU), buffers them in order and drains one per cycle into the single RF write port (dest / write_enable / data_in).
- Exposes bypass lookups so read-port consumers see values that are still queued and not yet written.

Parameters:
- DEPTH, 4, queue entries; power of two, ≥2.
- ADDR_W, 3, register address width (matches 8-entry RF).
- DATA_W, 32, data width.
- ZERO_DISCARD, 0, if 1 a completed handshake with dest==0 is accepted but not enqueued.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_dest  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- lsu_valid  in  1  LSU result valid.
- lsu_ready  out  1  LSU result accepted this cycle.
- lsu_dest  in  ADDR_W  LSU destination register.
- lsu_data  in  DATA_W  LSU result.
- wb_hold  in  1  freeze draining; no RF write this cycle.
- rf_write_enable  out  1  RF write strobe.
- rf_dest  out  ADDR_W  RF write address.
- rf_data  out  DATA_W  RF write data.
- src_one  in  ADDR_W  read port 1 address for bypass lookup.
- src_two  in  ADDR_W  read port 2 address for bypass lookup.
- byp_one_hit  out  1  src_one matches a queued entry.
- byp_one_data  out  DATA_W  youngest matching data for src_one.
- byp_two_hit  out  1  src_two matches a queued entry.
- byp_two_data  out  DATA_W  youngest matching data for src_two.
- count  out  clog2(DEPTH)+1  entries held.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Reset state:
  - count=0, rd_ptr=wr_ptr=0, full=0, empty=1.
  - Round-robin pointer favours ALU first.
  - All queued entries are discarded.
  - While reset is high, both ready outputs are 0 and rf_write_enable=0.
- Handshake:
  - A transfer occurs on a rising edge with valid&ready.
  - Producers hold valid, dest and data stable until ready.
  - ready may depend combinationally on the other port's valid, never on its own valid.
- Enqueue, at most one per cycle:
  - Eligible iff !full. Space freed by a same-cycle drain is NOT counted, so full blocks enqueue even while draining.
  - One valid: that port gets ready=1.
  - Both valid: the port not granted last time wins. The round-robin pointer updates only on an actual transfer.
- Entry: {dest, data} written at wr_ptr; wr_ptr wraps modulo DEPTH.
- ZERO_DISCARD=1 with dest==0: handshake completes, nothing is enqueued, count unchanged.
- Drain:
  - rf_write_enable = !empty & !wb_hold (combinational).
  - rf_dest/rf_data = head entry when !empty, else 0.
  - On rf_write_enable the head pops at the edge; rd_ptr wraps modulo DEPTH.
  - Latency: a result accepted at edge N into an empty queue presents rf_write_enable during cycle N..N+1 and lands in the RF at edge N+1.
- Simultaneous enqueue+pop: count unchanged, order preserved (FIFO).
- Bypass, combinational:
  - Search all valid entries for dest==src.
  - Youngest match wins (most recently enqueued), including the head currently being written.
  - No match: hit=0, data=0.
  - Incoming producer data is not bypassed.
- count is registered: increments on enqueue, decrements on pop, both means no change.

Test Plan:
- Reset, then alu_valid=1, dest=3, data=0xDEADBEEF → alu_ready=1; next cycle rf_write_enable=1, rf_dest=3, rf_data=0xDEADBEEF; queue empty again after the following edge.
- wb_hold=1, four ALU writes to dest 1,2,3,4 → full=1, count=4, alu_ready=0 on a fifth; release hold → drains 1,2,3,4 in order, one per cycle.
- Both ports valid for 4 cycles with the queue never full → grants alternate ALU, LSU, ALU, LSU; each producer's data appears on rf_* in accept order.
- Hold on, enqueue dest=5 data=0x11 then dest=5 data=0x22, src_one=5, src_two=6 → byp_one_hit=1, byp_one_data=0x22; byp_two_hit=0, byp_two_data=0.
- ZERO_DISCARD=1, write dest=0 → ready=1, count stays 0, no rf_write_enable. With ZERO_DISCARD=0 → written normally.
- Queue holding 3 entries with hold on, assert reset for one cycle → count=0, empty=1, no RF write occurs afterwards, ready outputs low during reset.
